// File: rtl/priv_trap_if.sv
// Commit-stage / fetch-side bundle for the privileged register file and trap sequencer.
// The master drives the in_* signals, the slave (trap unit) drives the out_* signals.
interface priv_trap_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 3,
  parameter int EXC_W = 3,
  parameter int CNT_W = 16
);
  logic [IDX_W-1:0] in_rm_idx;
  logic             in_write_enable;
  logic [XLEN-1:0]  in_write_data;
  logic [IDX_W-1:0] in_read_idx;
  logic [XLEN-1:0]  out_read_data;
  logic [EXC_W-1:0] in_exception_vector;
  logic [XLEN-1:0]  in_fault_pc;
  logic [XLEN-1:0]  in_fault_addr;
  logic [XLEN-1:0]  in_additional_info;
  logic             out_supervisor_mode;
  logic             out_overwrite_PC;
  logic [XLEN-1:0]  out_new_address;
  logic             out_iret;
  logic             out_priv_violation;
  logic             out_halted;
  logic [CNT_W-1:0] out_trap_count;

  modport master (
    output in_rm_idx, in_write_enable, in_write_data, in_read_idx,
           in_exception_vector, in_fault_pc, in_fault_addr, in_additional_info,
    input  out_read_data, out_supervisor_mode, out_overwrite_PC, out_new_address,
           out_iret, out_priv_violation, out_halted, out_trap_count
  );

  modport slave (
    input  in_rm_idx, in_write_enable, in_write_data, in_read_idx,
           in_exception_vector, in_fault_pc, in_fault_addr, in_additional_info,
    output out_read_data, out_supervisor_mode, out_overwrite_PC, out_new_address,
           out_iret, out_priv_violation, out_halted, out_trap_count
  );
endinterface

// File: rtl/priv_trap_unit.sv
// Privileged register file plus trap sequencer: captures exception state, redirects fetch,
// services iret, blocks user writes, halts on double fault and counts traps.
module priv_trap_unit #(
  parameter int          XLEN           = 32,
  parameter int          NUM_RM         = 8,
  parameter int          EXC_W          = 3,
  parameter int unsigned HANDLER_BASE   = 32'h2000,
  parameter int          VECTORED       = 1,
  parameter int unsigned VEC_STRIDE     = 16,
  parameter int unsigned BOOT_RETURN_PC = 32'h1000,
  parameter int          CNT_W          = 16
) (
  input logic       clk,
  input logic       reset,
  priv_trap_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_RM);
  localparam logic [XLEN-1:0]  BASE    = XLEN'(HANDLER_BASE);
  localparam logic [XLEN-1:0]  STRIDE  = XLEN'(VEC_STRIDE);
  localparam logic [XLEN-1:0]  BOOT_PC = XLEN'(BOOT_RETURN_PC);
  localparam logic [IDX_W:0]   RM_CNT  = (IDX_W+1)'(NUM_RM);
  localparam logic [IDX_W-1:0] STATUS  = IDX_W'(4);

  typedef enum logic [1:0] {USER, SUPER, HALTED} mode_e;

  mode_e                         state_q, state_d;
  logic [NUM_RM-1:0][XLEN-1:0]   rm_q, rm_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          ovr_q, ovr_d, iret_q, iret_d, viol_q, viol_d;
  logic [XLEN-1:0]               addr_q, addr_d;
  logic [XLEN-1:0]               handler;
  logic                          wr_ok, rd_ok, exc;

  assign exc   = bus.in_exception_vector != '0;
  assign wr_ok = {1'b0, bus.in_rm_idx} < RM_CNT;
  assign rd_ok = {1'b0, bus.in_read_idx} < RM_CNT;
  // Vector offset wraps at XLEN bits by construction of the operand widths.
  assign handler = (VECTORED != 0) ? BASE + XLEN'(bus.in_exception_vector) * STRIDE : BASE;

  always_comb begin
    state_d = state_q;
    rm_d    = rm_q;
    cnt_d   = cnt_q;
    ovr_d   = 1'b0;
    addr_d  = '0;
    iret_d  = 1'b0;
    viol_d  = 1'b0;
    if (state_q != HALTED) begin
      if (exc) begin
        rm_d[0] = bus.in_fault_pc;
        rm_d[1] = bus.in_fault_addr;
        rm_d[2] = bus.in_additional_info;
        rm_d[3] = XLEN'(bus.in_exception_vector);
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (state_q == USER) begin
          rm_d[4][1] = 1'b0;
          rm_d[4][0] = 1'b1;
          state_d    = SUPER;
          ovr_d      = 1'b1;
          addr_d     = handler;
        end else begin
          state_d = HALTED;
        end
      end else if (bus.in_write_enable && wr_ok) begin
        if (state_q == USER) begin
          viol_d = 1'b1;
        end else begin
          rm_d[bus.in_rm_idx] = bus.in_write_data;
          // A status write is an iret: return to the PC held before this cycle's write.
          if (bus.in_rm_idx == STATUS) begin
            ovr_d   = 1'b1;
            addr_d  = rm_q[0];
            iret_d  = 1'b1;
            state_d = bus.in_write_data[0] ? SUPER : USER;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SUPER;
      rm_q    <= '0;
      rm_q[0] <= BOOT_PC;
      rm_q[4] <= XLEN'(1);
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      addr_q  <= '0;
      iret_q  <= 1'b0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rm_q    <= rm_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      addr_q  <= addr_d;
      iret_q  <= iret_d;
      viol_q  <= viol_d;
    end
  end

  assign bus.out_read_data       = rd_ok ? rm_q[bus.in_read_idx] : '0;
  assign bus.out_supervisor_mode = rm_q[4][0];
  assign bus.out_overwrite_PC    = ovr_q;
  assign bus.out_new_address     = addr_q;
  assign bus.out_iret            = iret_q;
  assign bus.out_priv_violation  = viol_q;
  assign bus.out_halted          = (state_q == HALTED);
  assign bus.out_trap_count      = cnt_q;
endmodule

// File: tb/tb_priv_trap_unit.sv
// Scenario bench for priv_trap_unit: expected pulse records are queued as stimulus is driven
// and popped against the registered outputs one cycle later.
module tb_priv_trap_unit;
  localparam int XLEN = 32, IDX_W = 3, EXC_W = 3, CW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  priv_trap_if #(.XLEN(XLEN), .IDX_W(IDX_W), .EXC_W(EXC_W), .CNT_W(CW)) bus ();

  priv_trap_unit #(
    .XLEN(XLEN), .NUM_RM(8), .EXC_W(EXC_W), .HANDLER_BASE(32'h2000), .VECTORED(1),
    .VEC_STRIDE(16), .BOOT_RETURN_PC(32'h1000), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic        ovr;
    logic [31:0] addr;
    logic        iret;
    logic        viol;
  } pulse_t;

  pulse_t sb[$];
  pulse_t exp_p, got_p;
  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic [31:0] last_pc;

  task automatic idle();
    bus.in_rm_idx           = '0;
    bus.in_write_enable     = 1'b0;
    bus.in_write_data       = '0;
    bus.in_exception_vector = '0;
    bus.in_fault_pc         = '0;
    bus.in_fault_addr       = '0;
    bus.in_additional_info  = '0;
  endtask

  task automatic drive(input logic we, input logic [2:0] idx, input logic [31:0] data,
                       input logic [2:0] cause, input logic [31:0] pc,
                       input logic [31:0] fa, input logic [31:0] info);
    bus.in_write_enable     = we;
    bus.in_rm_idx           = idx;
    bus.in_write_data       = data;
    bus.in_exception_vector = cause;
    bus.in_fault_pc         = pc;
    bus.in_fault_addr       = fa;
    bus.in_additional_info  = info;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    bus.in_read_idx = '0;
    reset = 1'b1;
    #12;
    tests++; if (bus.out_read_data !== 32'h1000) begin $display("FAIL reset_rm0 got %h want %h", bus.out_read_data, 32'h1000); fails++; end
    bus.in_read_idx = 3'd4; #1;
    tests++; if (bus.out_read_data !== 32'h1) begin $display("FAIL reset_rm4 got %h want %h", bus.out_read_data, 32'h1); fails++; end
    tests++; if ({bus.out_supervisor_mode, bus.out_overwrite_PC, bus.out_halted, bus.out_trap_count} !== 6'b100_000)
      begin $display("FAIL reset_outs got %b%b%b %0d want 100 0", bus.out_supervisor_mode, bus.out_overwrite_PC, bus.out_halted, bus.out_trap_count); fails++; end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    exp_cnt = 0;
  endtask

  task automatic test_iret();
    sb.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
    drive(1'b1, 3'd0, 32'h400, 3'd0, 0, 0, 0);
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL iret_setup got %h want %h", got_p, exp_p); fails++; end
    sb.push_back('{1'b1, 32'h400, 1'b1, 1'b0});
    drive(1'b1, 3'd4, 32'h0, 3'd0, 0, 0, 0);
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL iret_pulse got %h want %h", got_p, exp_p); fails++; end
    tests++; if (bus.out_supervisor_mode !== 1'b0) begin $display("FAIL iret_mode got %b want 0", bus.out_supervisor_mode); fails++; end
    sb.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
    drive(1'b0, 3'd0, 0, 3'd0, 0, 0, 0);
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL iret_one_cycle got %h want %h", got_p, exp_p); fails++; end
  endtask

  task automatic test_user_write();
    sb.push_back('{1'b0, 32'h0, 1'b0, 1'b1});
    drive(1'b1, 3'd5, 32'hDEAD, 3'd0, 0, 0, 0);
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL viol_pulse got %h want %h", got_p, exp_p); fails++; end
    sb.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
    drive(1'b0, 3'd0, 0, 3'd0, 0, 0, 0);
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL viol_once got %h want %h", got_p, exp_p); fails++; end
    bus.in_read_idx = 3'd5; #1;
    tests++; if (bus.out_read_data !== 32'h0) begin $display("FAIL viol_rm5 got %h want 0", bus.out_read_data); fails++; end
  endtask

  task automatic test_trap();
    sb.push_back('{1'b1, 32'h2030, 1'b0, 1'b0});
    drive(1'b0, 3'd0, 0, 3'd3, 32'h408, 32'hA0, 32'hB0);
    exp_cnt++; last_pc = 32'h408;
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL trap_redirect got %h want %h", got_p, exp_p); fails++; end
    tests++; if (bus.out_trap_count !== CW'(exp_cnt)) begin $display("FAIL trap_count got %0d want %0d", bus.out_trap_count, exp_cnt); fails++; end
    bus.in_read_idx = 3'd0; #1;
    tests++; if (bus.out_read_data !== 32'h408) begin $display("FAIL trap_rm0 got %h want 408", bus.out_read_data); fails++; end
    bus.in_read_idx = 3'd1; #1;
    tests++; if (bus.out_read_data !== 32'hA0) begin $display("FAIL trap_rm1 got %h want a0", bus.out_read_data); fails++; end
    bus.in_read_idx = 3'd2; #1;
    tests++; if (bus.out_read_data !== 32'hB0) begin $display("FAIL trap_rm2 got %h want b0", bus.out_read_data); fails++; end
    bus.in_read_idx = 3'd3; #1;
    tests++; if (bus.out_read_data !== 32'h3) begin $display("FAIL trap_rm3 got %h want 3", bus.out_read_data); fails++; end
    bus.in_read_idx = 3'd4; #1;
    tests++; if (bus.out_read_data !== 32'h1) begin $display("FAIL trap_rm4 got %h want 1", bus.out_read_data); fails++; end
  endtask

  task automatic test_same_cycle();
    sb.push_back('{1'b1, last_pc, 1'b1, 1'b0});
    drive(1'b1, 3'd4, 32'h0, 3'd0, 0, 0, 0);
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL same_iret got %h want %h", got_p, exp_p); fails++; end
    sb.push_back('{1'b1, 32'h2010, 1'b0, 1'b0});
    drive(1'b1, 3'd4, 32'hFF, 3'd1, 32'h40C, 0, 0);
    exp_cnt++; last_pc = 32'h40C;
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL same_trap got %h want %h", got_p, exp_p); fails++; end
    bus.in_read_idx = 3'd4; #1;
    tests++; if (bus.out_read_data !== 32'h1) begin $display("FAIL same_rm4 got %h want 1", bus.out_read_data); fails++; end
    tests++; if (bus.out_trap_count !== CW'(exp_cnt)) begin $display("FAIL same_count got %0d want %0d", bus.out_trap_count, exp_cnt); fails++; end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      logic [2:0] c;
      logic [31:0] pc;
      c  = 3'(i % 7 + 1);
      pc = 32'h500 + 32'(i) * 4;
      sb.push_back('{1'b1, last_pc, 1'b1, 1'b0});
      drive(1'b1, 3'd4, 32'h0, 3'd0, 0, 0, 0);
      exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
      tests++; if (got_p !== exp_p) begin $display("FAIL b2b_iret[%0d] got %h want %h", i, got_p, exp_p); fails++; end
      sb.push_back('{1'b1, 32'h2000 + 32'(c) * 16, 1'b0, 1'b0});
      drive(1'b0, 3'd0, 0, c, pc, 0, 0);
      last_pc = pc;
      if (exp_cnt < (1 << CW) - 1) exp_cnt++;
      exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
      tests++; if (got_p !== exp_p) begin $display("FAIL b2b_trap[%0d] got %h want %h", i, got_p, exp_p); fails++; end
      tests++; if (bus.out_trap_count !== CW'(exp_cnt)) begin $display("FAIL b2b_count[%0d] got %0d want %0d", i, bus.out_trap_count, exp_cnt); fails++; end
    end
    sb.push_back('{1'b1, last_pc, 1'b1, 1'b0});
    drive(1'b1, 3'd4, 32'h1, 3'd0, 0, 0, 0);
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL iret_super got %h want %h", got_p, exp_p); fails++; end
    tests++; if (bus.out_supervisor_mode !== 1'b1) begin $display("FAIL iret_super_mode got %b want 1", bus.out_supervisor_mode); fails++; end
  endtask

  task automatic test_double_fault();
    sb.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
    drive(1'b0, 3'd0, 0, 3'd2, 32'h900, 32'h11, 32'h22);
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL dbl_no_redirect got %h want %h", got_p, exp_p); fails++; end
    tests++; if (bus.out_halted !== 1'b1) begin $display("FAIL dbl_halted got %b want 1", bus.out_halted); fails++; end
    bus.in_read_idx = 3'd0; #1;
    tests++; if (bus.out_read_data !== 32'h900) begin $display("FAIL dbl_rm0 got %h want 900", bus.out_read_data); fails++; end
    sb.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
    drive(1'b0, 3'd0, 0, 3'd6, 32'hAAA, 0, 0);
    sb.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL halt_exc got %h want %h", got_p, exp_p); fails++; end
    drive(1'b1, 3'd0, 32'h123, 3'd0, 0, 0, 0);
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL halt_write got %h want %h", got_p, exp_p); fails++; end
    #1;
    tests++; if (bus.out_read_data !== 32'h900) begin $display("FAIL halt_rm0 got %h want 900", bus.out_read_data); fails++; end
    tests++; if (bus.out_halted !== 1'b1 || bus.out_trap_count !== CW'(exp_cnt))
      begin $display("FAIL halt_hold got %b %0d want 1 %0d", bus.out_halted, bus.out_trap_count, exp_cnt); fails++; end
  endtask

  task automatic test_reset_mid_trap();
    test_reset();
    tests++; if (bus.out_halted !== 1'b0) begin $display("FAIL reset_unhalt got %b want 0", bus.out_halted); fails++; end
    sb.push_back('{1'b1, 32'h1000, 1'b1, 1'b0});
    drive(1'b1, 3'd4, 32'h0, 3'd0, 0, 0, 0);
    exp_p = sb.pop_front(); got_p = {bus.out_overwrite_PC, bus.out_new_address, bus.out_iret, bus.out_priv_violation};
    tests++; if (got_p !== exp_p) begin $display("FAIL boot_iret got %h want %h", got_p, exp_p); fails++; end
    bus.in_exception_vector = 3'd3;
    bus.in_fault_pc         = 32'h777;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    idle();
    bus.in_read_idx = 3'd0; #1;
    tests++; if ({bus.out_overwrite_PC, bus.out_new_address, bus.out_trap_count} !== '0)
      begin $display("FAIL mid_trap_redirect got %b %h %0d want 0 0 0", bus.out_overwrite_PC, bus.out_new_address, bus.out_trap_count); fails++; end
    tests++; if (bus.out_read_data !== 32'h1000 || bus.out_supervisor_mode !== 1'b1)
      begin $display("FAIL mid_trap_state got %h %b want 1000 1", bus.out_read_data, bus.out_supervisor_mode); fails++; end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.in_read_idx = '0;
    idle();
    test_reset();
    test_iret();
    test_user_write();
    test_trap();
    test_same_cycle();
    test_back_to_back();
    test_double_fault();
    test_reset_mid_trap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
